// File: rtl/ahb_traffic_gen.sv
// ahb_traffic_gen
//   AHB-Lite master traffic generator. On a start pulse it writes
//   data(i) = 32'hC0DE_0000 | i to NUM_WORDS consecutive words starting at
//   BASE_ADDR. It then reads the same words back and checks each one. It
//   reports completion on done_r. Mismatches and ERROR responses are reported
//   on error_r (sticky for the run) and err_count (saturating).
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   start      in   run request, honoured in IDLE or DONE only
//   haddr      out  [31:0] address phase address
//   htrans     out  [1:0]  IDLE (00) or NONSEQ (10)
//   hwrite     out  transfer direction (1 = write)
//   hsize      out  [2:0]  constant word size
//   hburst     out  [2:0]  constant SINGLE
//   hwdata     out  [31:0] write data for the transfer in data phase
//   hrdata     in   [31:0] read data
//   hready     in   1 = current data phase completes / address accepted
//   hresp      in   0 = OKAY, 1 = ERROR
//   done_r     out  run complete
//   error_r    out  any mismatch or ERROR response seen in this run
//   err_count  out  [15:0] number of failing transfers, saturates at FFFF

module ahb_traffic_gen #(
  parameter int unsigned NUM_WORDS = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [31:0] haddr,
  output logic [1:0]  htrans,
  output logic        hwrite,
  output logic [2:0]  hsize,
  output logic [2:0]  hburst,
  output logic [31:0] hwdata,
  input  logic [31:0] hrdata,
  input  logic        hready,
  input  logic        hresp,
  output logic        done_r,
  output logic        error_r,
  output logic [15:0] err_count
);

  localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
  localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;
  localparam logic [15:0] LAST_IDX      = 16'(NUM_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_LAST,
    S_DONE
  } state_t;

  state_t      state;
  logic [15:0] idx;       // index of the transfer in address phase
  logic        dp_valid;  // a transfer is in its data phase
  logic        dp_write;
  logic [15:0] dp_idx;    // index of the transfer in data phase
  logic        dp_done;
  logic        dp_bad;

  function automatic logic [31:0] pattern(input logic [15:0] i);
    return 32'hC0DE_0000 | {16'h0000, i};
  endfunction

  assign hsize  = 3'b010;
  assign hburst = 3'b000;

  // A data phase fails on an ERROR completion, or on an OKAY read whose data
  // does not match the pattern. Reads that complete with ERROR are not compared.
  always_comb begin
    dp_done = dp_valid && hready;
    dp_bad  = dp_done && (hresp || (!dp_write && (hrdata != pattern(dp_idx))));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      idx       <= '0;
      dp_valid  <= 1'b0;
      dp_write  <= 1'b0;
      dp_idx    <= '0;
      haddr     <= '0;
      htrans    <= HTRANS_IDLE;
      hwrite    <= 1'b0;
      hwdata    <= '0;
      done_r    <= 1'b0;
      error_r   <= 1'b0;
      err_count <= '0;
    end else begin
      // Pipeline advance: when hready is high, the transfer in address phase
      // moves into data phase. For a write, its data goes on hwdata
      // in the same step.
      if (hready) begin
        dp_valid <= (htrans == HTRANS_NONSEQ);
        dp_write <= hwrite;
        dp_idx   <= idx;
        if ((htrans == HTRANS_NONSEQ) && hwrite) begin
          hwdata <= pattern(idx);
        end
      end

      if (dp_bad) begin
        error_r <= 1'b1;
        if (err_count != '1) begin
          err_count <= err_count + 16'd1;
        end
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_WR;
            idx       <= '0;
            haddr     <= BASE_ADDR;
            htrans    <= HTRANS_NONSEQ;
            hwrite    <= 1'b1;
            done_r    <= 1'b0;
            error_r   <= 1'b0;
            err_count <= '0;
          end
        end

        S_WR: begin
          if (hready) begin
            if (idx == LAST_IDX) begin
              // First read address phase overlaps the last write data phase.
              state  <= S_RD;
              idx    <= '0;
              haddr  <= BASE_ADDR;
              hwrite <= 1'b0;
            end else begin
              idx   <= idx + 16'd1;
              haddr <= haddr + 32'd4;
            end
          end
        end

        S_RD: begin
          if (hready) begin
            if (idx == LAST_IDX) begin
              state  <= S_LAST;
              htrans <= HTRANS_IDLE;
            end else begin
              idx   <= idx + 16'd1;
              haddr <= haddr + 32'd4;
            end
          end
        end

        S_LAST: begin
          // The final read data phase is checked by the shared logic above.
          if (hready) begin
            state <= S_DONE;
          end
        end

        S_DONE: begin
          done_r <= 1'b1;
          if (start) begin
            state     <= S_WR;
            idx       <= '0;
            haddr     <= BASE_ADDR;
            htrans    <= HTRANS_NONSEQ;
            hwrite    <= 1'b1;
            done_r    <= 1'b0;
            error_r   <= 1'b0;
            err_count <= '0;
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_traffic_gen.sv
// tb_ahb_traffic_gen
//   Bench for ahb_traffic_gen with NUM_WORDS=4 and BASE_ADDR=0. A behavioural
//   AHB slave drives the generator. For each transfer, the slave can add wait
//   cycles, return a two-cycle ERROR response, or corrupt the read data. The
//   expected cycle counts, error counts and transfer sequence come from
//   arithmetic over those settings.

module tb_ahb_traffic_gen;

  localparam int NW = 4;
  localparam int NT = 2 * NW;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic [31:0] hrdata;
  logic        hready;
  logic        hresp;
  logic        done_r;
  logic        error_r;
  logic [15:0] err_count;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  ahb_traffic_gen #(
    .NUM_WORDS(NW),
    .BASE_ADDR(32'h0000_0000)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .haddr(haddr), .htrans(htrans), .hwrite(hwrite),
    .hsize(hsize), .hburst(hburst), .hwdata(hwdata),
    .hrdata(hrdata), .hready(hready), .hresp(hresp),
    .done_r(done_r), .error_r(error_r), .err_count(err_count)
  );

  // ---------------- slave model ----------------
  int          wait_tab [NT];
  bit          err_tab  [NT];
  bit          corrupt_tab [NW];
  logic [31:0] mem [16];
  logic [32:0] alog [$];   // {hwrite, haddr} of each accepted address phase
  logic [31:0] wlog [$];   // hwdata of each completed write
  logic        dph_valid = 1'b0;
  logic        dph_write = 1'b0;
  logic [31:0] dph_addr  = '0;
  int          dph_k     = 0;
  int          wait_cnt  = 0;

  always_comb begin
    hready = 1'b1;
    hresp  = 1'b0;
    hrdata = '0;
    if (dph_valid) begin
      if (dph_k < NT && err_tab[dph_k]) begin
        hready = (wait_cnt >= 1);
        hresp  = 1'b1;
      end else if (dph_k < NT) begin
        hready = (wait_cnt >= wait_tab[dph_k]);
      end
      if (!dph_write) begin
        hrdata = mem[dph_addr[5:2]];
        if (dph_k >= NW && dph_k < NT && corrupt_tab[dph_k - NW]) hrdata[0] = ~hrdata[0];
      end
    end
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      dph_valid <= 1'b0;
      wait_cnt  <= 0;
    end else if (hready) begin
      if (dph_valid && dph_write) begin
        mem[dph_addr[5:2]] <= hwdata;
        wlog.push_back(hwdata);
      end
      dph_valid <= htrans[1];
      dph_write <= hwrite;
      dph_addr  <= haddr;
      wait_cnt  <= 0;
      if (htrans[1]) begin
        dph_k <= alog.size();
        alog.push_back({hwrite, haddr});
      end
    end else begin
      wait_cnt <= wait_cnt + 1;
    end
  end

  // ---------------- hold check during wait cycles ----------------
  logic [31:0] p_addr  = '0;
  logic [31:0] p_wdata = '0;
  logic [1:0]  p_trans = '0;
  logic        p_write = 1'b0;
  logic        p_ready = 1'b1;
  logic        p_rst   = 1'b0;

  always @(negedge clk) begin
    if (p_rst && rst_n && !p_ready) begin
      tests++;
      if ({haddr, htrans, hwrite, hwdata} !== {p_addr, p_trans, p_write, p_wdata}) begin
        failed++;
        $display("FAIL hold: got addr=%h trans=%b wr=%b wdata=%h expected addr=%h trans=%b wr=%b wdata=%h",
                 haddr, htrans, hwrite, hwdata, p_addr, p_trans, p_write, p_wdata);
      end
    end
    p_addr  <= haddr;
    p_trans <= htrans;
    p_write <= hwrite;
    p_wdata <= hwdata;
    p_ready <= hready;
    p_rst   <= rst_n;
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Expected results for the current slave settings. Transfer k's data phase
  // completes at edge 2 + k + (waits of transfers 0..k). An ERROR transfer
  // costs one wait. done_r rises one edge after the last completion.
  task automatic model(output int exp_done, output int exp_errc, output int exp_first);
    int w_sum;
    int w;
    bit bad;
    w_sum = 0;
    exp_errc = 0;
    exp_first = -1;
    for (int k = 0; k < NT; k++) begin
      w = err_tab[k] ? 1 : wait_tab[k];
      w_sum += w;
      bad = err_tab[k] || (k >= NW && corrupt_tab[k - NW]);
      if (bad) begin
        exp_errc++;
        if (exp_first < 0) exp_first = 2 + k + w_sum;
      end
    end
    exp_done = 2 * NW + 2 + w_sum;
  endtask

  task automatic check_log(input string nm);
    logic [32:0] exp_a;
    chk({nm, " ntrans"}, alog.size(), NT);
    for (int k = 0; k < NT && k < alog.size(); k++) begin
      exp_a = {(k < NW) ? 1'b1 : 1'b0, 32'(4 * (k % NW))};
      chk($sformatf("%s xfer%0d", nm, k), alog[k], exp_a);
    end
    chk({nm, " nwrites"}, wlog.size(), NW);
    for (int k = 0; k < NW && k < wlog.size(); k++) begin
      chk($sformatf("%s wdata%0d", nm, k), wlog[k], 32'hC0DE_0000 | 32'(k));
    end
  endtask

  // One full run from IDLE or DONE. If pulse_cyc >= 0, start is pulsed again
  // so that it is sampled on edge pulse_cyc+1.
  task automatic do_run(input string nm, input int exp_done, input int exp_errc,
                        input int exp_first, input int pulse_cyc);
    int cyc;
    int first;
    alog.delete();
    wlog.delete();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk({nm, " clr"}, {done_r, error_r, err_count}, 18'h0);
    cyc = 0;
    first = -1;
    while (!done_r && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      start = (cyc == pulse_cyc);
      if (first < 0 && error_r) first = cyc;
    end
    start = 1'b0;
    chk({nm, " done_cyc"}, cyc, exp_done);
    chk({nm, " error_r"}, error_r, (exp_errc != 0));
    chk({nm, " err_count"}, err_count, exp_errc);
    chk({nm, " err_edge"}, first, exp_first);
    check_log(nm);
  endtask

  typedef struct {
    int waits;
    int corrupt_word;
    int err_a;
    int err_b;
    int exp_done;
    int exp_errc;
    int exp_first;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int ed, ec, ef;

    vecs[0] = '{waits: 0, corrupt_word: -1, err_a: -1, err_b: -1, exp_done: 10, exp_errc: 0, exp_first: -1};
    vecs[1] = '{waits: 2, corrupt_word: -1, err_a: -1, err_b: -1, exp_done: 26, exp_errc: 0, exp_first: -1};
    vecs[2] = '{waits: 0, corrupt_word: 2,  err_a: -1, err_b: -1, exp_done: 10, exp_errc: 1, exp_first: 8};
    vecs[3] = '{waits: 0, corrupt_word: -1, err_a: 1,  err_b: 7,  exp_done: 12, exp_errc: 2, exp_first: 4};

    for (int k = 0; k < NT; k++) begin
      wait_tab[k] = 0;
      err_tab[k]  = 1'b0;
    end
    for (int k = 0; k < NW; k++) corrupt_tab[k] = 1'b0;
    for (int k = 0; k < 16; k++) mem[k] = '0;

    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst bus", {haddr, htrans, hwrite, hwdata}, {32'h0, 2'b00, 1'b0, 32'h0});
    chk("rst status", {done_r, error_r, err_count}, 18'h0);
    chk("rst const", {hsize, hburst}, {3'b010, 3'b000});
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int v = 0; v < 4; v++) begin
      for (int k = 0; k < NT; k++) begin
        wait_tab[k] = vecs[v].waits;
        err_tab[k]  = (k == vecs[v].err_a) || (k == vecs[v].err_b);
      end
      for (int k = 0; k < NW; k++) corrupt_tab[k] = (k == vecs[v].corrupt_word);
      do_run($sformatf("vec%0d", v), vecs[v].exp_done, vecs[v].exp_errc, vecs[v].exp_first, -1);
    end

    // start pulsed while reading is ignored
    for (int k = 0; k < NT; k++) begin
      wait_tab[k] = 0;
      err_tab[k]  = 1'b0;
    end
    for (int k = 0; k < NW; k++) corrupt_tab[k] = 1'b0;
    do_run("start_in_rd", 10, 0, -1, 6);

    // reset during the write phase, then a clean rerun
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("midrst bus", {htrans, haddr, hwrite}, {2'b00, 32'h0, 1'b0});
    chk("midrst status", {done_r, error_r, err_count}, 18'h0);
    @(posedge clk);
    #1;
    chk("midrst idle", htrans, 2'b00);
    do_run("after_rst", 10, 0, -1, -1);

    // randomized slave behaviour
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < NT; k++) begin
        wait_tab[k] = int'($urandom_range(0, 3));
        err_tab[k]  = ($urandom_range(0, 4) == 0);
      end
      for (int k = 0; k < NW; k++) corrupt_tab[k] = ($urandom_range(0, 3) == 0);
      model(ed, ec, ef);
      do_run($sformatf("rnd%0d", r), ed, ec, ef, -1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/ahb_traffic_gen.md
# ahb_traffic_gen

AHB-Lite master traffic generator sitting directly upstream of `ahb_to_ssram`, driving its slave port. On `start` it writes a deterministic pattern to `NUM_WORDS` consecutive words, reads them back, and compares each returned word. It flags completion on `done_r` and mismatches on `error_r`/`err_count`, giving the bridge and SSRAM a self-checking stimulus source for simulation and bring-up.

## Interface

Parameters:
- `NUM_WORDS`, 16: words written then read; legal range 1..65535.
- `BASE_ADDR`, 32'h0000_0000: byte address of word 0; must be word-aligned.

Ports:
- `clk`, in, 1: single clock; all logic on the rising edge.
- `rst_n`, in, 1: reset, synchronous and active-low.
- `start`, in, 1: one-cycle pulse that starts a run. Accepted only in IDLE or DONE.
- `haddr`, out, 32: AHB address.
- `htrans`, out, 2: 2'b00 IDLE or 2'b10 NONSEQ only.
- `hwrite`, out, 1: transfer direction.
- `hsize`, out, 3: constant 3'b010 (word).
- `hburst`, out, 3: constant 3'b000 (SINGLE).
- `hwdata`, out, 32: write data, driven in the data phase.
- `hrdata`, in, 32: read data.
- `hready`, in, 1: transfer done / wait state.
- `hresp`, in, 1: 0 OKAY, 1 ERROR.
- `done_r`, out, 1: run complete.
- `error_r`, out, 1: sticky; set by any mismatch or any ERROR response in the run.
- `err_count`, out, 16: errors counted in the run; saturates at 16'hFFFF.

## Operation

- Pattern:
  - data(i) = 32'hC0DE_0000 | i[15:0].
  - addr(i) = BASE_ADDR + 4*i, 32-bit wrap-around.
- States:
  - IDLE: on `start`, go to WR with i=0. Clear `done_r`, `error_r` and `err_count`.
  - WR: drive address phase i with `hwrite`=1 and `htrans`=NONSEQ. Advance i only when `hready`=1. After write N-1 is accepted, go to RD with i=0.
  - RD: drive address phase i with `hwrite`=0 and `htrans`=NONSEQ. Advance on `hready`=1. After read N-1 is accepted, go to LAST.
  - LAST: `htrans`=IDLE while waiting for the final read data phase. When `hready`=1, go to DONE.
  - DONE: `done_r`=1. A `start` here behaves as it does in IDLE.
- Pipelining:
  - An address phase overlaps the previous transfer's data phase.
  - `hwdata` = data(i) in the cycle after write i's address was accepted, and is held while `hready`=0.
  - The first read address phase overlaps the last write's data phase.
- Address and control outputs stay stable while `hready`=0.
- Read check: when a read data phase completes (`hready`=1 and `hresp`=0) with `hrdata` ≠ data(i), set `error_r` and increment `err_count`.
- ERROR response:
  - A data-phase cycle with `hready`=1 and `hresp`=1 (read or write) sets `error_r` and increments `err_count`.
  - For reads, no data compare is done on that transfer.
  - The first ERROR cycle (`hready`=0) is treated as a wait state. The pending transfer is not cancelled, and the sequence continues.
- `start` in WR, RD or LAST is ignored.
- A simultaneous `hready`=1 data-phase completion and address acceptance in one cycle are both processed in that cycle.

## Timing

- Reset values:
  - `haddr`=0, `htrans`=2'b00, `hwrite`=0, `hwdata`=0.
  - `done_r`=0, `error_r`=0, `err_count`=0, state IDLE.
  - `hsize` and `hburst` are constants.
- Reset mid-run: `rst_n`=0 sampled at an edge forces all reset values at that edge, whatever the state. Bus outputs become IDLE on the same edge.
- Latency with `hready` tied 1, `start` high at edge 0:
  - Write address phases at cycles 1..N.
  - Read address phases at cycles N+1..2N.
  - Final read data phase at cycle 2N+1.
  - `done_r` rises at edge 2N+2.
- Each wait cycle (`hready`=0) delays everything that follows by one cycle.
- `error_r` and `err_count` update on the edge that completes the offending data phase.

## Test plan

- Wait-state-free run: `NUM_WORDS`=4, `BASE_ADDR`=0, ideal zero-wait slave memory.
  - Writes go to 0x0, 0x4, 0x8 and 0xC with data C0DE0000..C0DE0003.
  - `done_r` rises 10 cycles after `start`; `error_r`=0 and `err_count`=0.
- Wait states: slave inserts 2 wait cycles on every transfer.
  - `haddr`/`hwdata` stay stable during waits.
  - `done_r` rises 26 cycles after `start`; `error_r`=0.
- Corrupted read: slave flips bit 0 of read word 2.
  - `error_r`=1 and `err_count`=1 after word 2's data phase; the run still completes.
- ERROR response: slave gives a two-cycle ERROR on write 1 and on read 3.
  - `err_count`=2 at DONE; all 8 transfers are issued.
- Mid-run reset and restart:
  - `rst_n` low for 1 cycle during WR: next cycle `htrans`=00, `haddr`=0, `done_r`=0.
  - A following `start` completes cleanly.
- Start handling:
  - `start` pulsed during RD is ignored: no restart, same cycle count.
  - `start` in DONE clears `done_r`, `error_r` and `err_count` the next cycle and reruns.
